seq_detect_ctrl: RTL

Run controller for the serial sequence detector. It latches a programmable bit pattern and run configuration on a start request, then steps the detector over a qualified serial stream. It counts matches in overlapping or non-overlapping mode and terminates the run on a target match count or on abort. It reports status to the host through busy, done and err.

---
 rtl/seq_detect_ctrl_if.sv | 32 +++
 rtl/seq_detect_ctrl.sv | 115 +++++++++++
 2 files changed

// File: rtl/seq_detect_ctrl_if.sv
// Host-side bundle for the sequence detector run controller: run request,
// run configuration, qualified serial stream and status outputs.
interface seq_detect_ctrl_if #(
    parameter int unsigned PW = 8,
    parameter int unsigned CW = 8
);
    logic          start;
    logic          abort;
    logic [PW-1:0] cfg_pattern;
    logic [4:0]    cfg_len;
    logic          cfg_overlap;
    logic [CW-1:0] cfg_target;
    logic          x;
    logic          x_valid;
    logic          y;
    logic          busy;
    logic          done;
    logic [CW-1:0] match_cnt;
    logic          err;

    // Host side drives requests, config and data; observes status.
    modport master (
        output start, abort, cfg_pattern, cfg_len, cfg_overlap, cfg_target, x, x_valid,
        input  y, busy, done, match_cnt, err
    );

    // Controller side.
    modport slave (
        input  start, abort, cfg_pattern, cfg_len, cfg_overlap, cfg_target, x, x_valid,
        output y, busy, done, match_cnt, err
    );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Run controller for the serial sequence detector. Latches the pattern and run
// configuration on an accepted start, shifts qualified bits, counts overlapping
// or non-overlapping matches and ends the run on a target count or on abort.
module seq_detect_ctrl #(
    parameter int unsigned PW = 8,
    parameter int unsigned CW = 8
) (
    input  logic             clk,
    input  logic             rst,
    seq_detect_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e        state_q;
    logic [PW-1:0] sr_q;
    logic [PW-1:0] pat_q;
    logic [4:0]    fill_q;
    logic [4:0]    len_q;
    logic          ovl_q;
    logic [CW-1:0] tgt_q;
    logic [CW-1:0] cnt_q;
    logic          y_q;
    logic          err_q;

    logic [PW-1:0] sr_n;
    logic [PW-1:0] len_mask;
    logic [4:0]    fill_n;
    logic [CW-1:0] cnt_inc;
    logic          hit;
    logic          tgt_hit;
    logic          cfg_ok;

    // Next shift/fill values for a qualified bit and the resulting match decision.
    always_comb begin
        sr_n   = {sr_q[PW-2:0], bus.x};
        // Fill never exceeds the latched length, so it saturates there.
        fill_n = (fill_q == len_q) ? len_q : fill_q + 5'd1;
        for (int i = 0; i < int'(PW); i++) begin
            len_mask[i] = (i < int'(len_q));
        end
        hit     = (fill_n == len_q) && (((sr_n ^ pat_q) & len_mask) == '0);
        cnt_inc = cnt_q + CW'(1);
        // Uses the unsaturated increment; a wrapped zero never equals a nonzero target.
        tgt_hit = (tgt_q != '0) && (cnt_inc == tgt_q);
        cfg_ok  = (bus.cfg_len != 5'd0) && (32'(bus.cfg_len) <= PW);
    end

    // Control FSM with all status outputs held in registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            sr_q    <= '0;
            pat_q   <= '0;
            fill_q  <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            tgt_q   <= '0;
            cnt_q   <= '0;
            y_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            y_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        if (cfg_ok) begin
                            pat_q   <= bus.cfg_pattern;
                            len_q   <= bus.cfg_len;
                            ovl_q   <= bus.cfg_overlap;
                            tgt_q   <= bus.cfg_target;
                            sr_q    <= '0;
                            fill_q  <= '0;
                            cnt_q   <= '0;
                            err_q   <= 1'b0;
                            state_q <= StRun;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (bus.abort) begin
                        // Abort wins over a coincident match: nothing is counted.
                        state_q <= StIdle;
                    end else if (bus.x_valid) begin
                        sr_q <= sr_n;
                        if (hit) begin
                            y_q    <= 1'b1;
                            cnt_q  <= (&cnt_q) ? cnt_q : cnt_inc;
                            // Non-overlap restarts the fill so the next match needs fresh bits.
                            fill_q <= ovl_q ? fill_n : 5'd0;
                            if (tgt_hit) begin
                                state_q <= StDone;
                            end
                        end else begin
                            fill_q <= fill_n;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.y         = y_q;
    assign bus.busy      = (state_q == StRun);
    assign bus.done      = (state_q == StDone);
    assign bus.match_cnt = cnt_q;
    assign bus.err       = err_q;
endmodule
